mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, placed in the execute stage beside the ALU.
- Operands come from the register-file read ports (rdata1 → A, rdata2 → B). The controller issues operations through a start/op strobe.
- busy tells the controller to stall any following MDU instruction.
- mduOut feeds the register-file write-data mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; asserted when 0, sampled on the rising edge of clk
- start  input  1  one-cycle issue strobe for mduOp
- mduOp  input  4  operation code (package constants)
- A  input  32  operand rs
- B  input  32  operand rt
- busy  output  1  high while a mult/div is in flight
- hi  output  32  current HI register
- lo  output  32  current LO register
- mduOut  output  32  read data: hi when mduOp==MDU_MFHI, else lo

Behaviour:
- Reset (reset==0 at an edge): HI=0, LO=0, busy=0, counter=0, state=IDLE. Reset aborts any in-flight operation and discards its result.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, counter counts down.
- Issue rule: start is honoured only when state==IDLE at the sampling edge.
  - start while BUSY is ignored: no state change, operands not latched. The controller must stall; the bench checks that ignored starts are harmless.
- MULT/MULTU/DIV/DIVU issued at edge T:
  - A and B are latched at edge T. Later changes on A/B have no effect.
  - busy=1 from after edge T for exactly N cycles, with N=MULT_CYCLES or DIV_CYCLES.
  - HI/LO update at edge T+N; busy falls at the same edge.
  - HI/LO hold their old values throughout BUSY.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
- Divide by zero (B==0 latched): the full busy latency still elapses; HI and LO remain unchanged.
- DIV overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO with start in IDLE: HI (or LO) ← A at edge T. These are single-cycle; busy never rises.
- MTHI/MTLO while BUSY: ignored, same as any other start while BUSY.
- MFHI/MFLO:
  - Purely combinational read through mduOut; start is irrelevant.
  - Valid any cycle, including while BUSY, where the pre-operation value is returned. The controller stalls mf* while busy to obtain the new value.
- Undefined or MDU_NONE opcode with start=1: no effect.
- Back-to-back issue: a new start is accepted in the cycle right after busy falls. It then sees the updated HI/LO, so mtlo straight after completion overwrites LO correctly.
- Counter width: enough bits to hold max(MULT_CYCLES, DIV_CYCLES). No wrap-around is possible, because the counter reloads only from IDLE.

Decomposition:
- Shared package (or shared define header) `mdu_defs` holds:
  - MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MFHI=5, MDU_MFLO=6, MDU_MTHI=7, MDU_MTLO=8
  - State encodings IDLE=0, BUSY=1
  
  The controller imports the same constants.
- No sub-module required. Result computation is combinational on the latched operands and is registered at completion. A separate `mdu_ctrl` FSM is unnecessary at this size.

Test Plan:
- Release reset, then mthi A=0x12345678 and mtlo A=0x9ABCDEF0 → hi=0x12345678, lo=0x9ABCDEF0 one edge later; busy stays 0.
- mult A=0xFFFFFFFE(-2), B=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. The same operands with multu → hi=0x00000002, lo=0xFFFFFFFA.
- div A=0xFFFFFFF9(-7), B=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 → lo=3, hi=1.
- Divide by zero: preload hi=0xAAAA0000, lo=0x0000BBBB, then div B=0 → busy for 10 cycles, HI/LO unchanged. Overflow 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- While busy, pulse start with mtlo A=0xDEADBEEF and change A/B → ignored, mult result is correct. mflo during busy → mduOut returns the old lo.
- Reset driven low in busy cycle 3 of a div → next edge gives busy=0, hi=lo=0. A fresh mult issued the following cycle completes normally.

Source files
------------

// File: rtl/mdu_defs.sv
// Shared opcode and state definitions for the multiply/divide unit.
// The controller imports this package so both sides agree on encodings.
package mdu_defs;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // Bits needed to hold the larger of the two latencies.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int max_cycles;
    max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched at issue; results land in HI/LO when busy falls.
module mult_div_unit
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mduOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mduOut
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [3:0]       op_q, op_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        div_zero, div_ovf;

  always_comb begin
    prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u   = {32'b0, a_q} * {32'b0, b_q};
    quot_s   = $signed(a_q) / $signed(b_q);
    rem_s    = $signed(a_q) % $signed(b_q);
    quot_u   = a_q / b_q;
    rem_u    = a_q % b_q;
    div_zero = (b_q == 32'b0);
    div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mduOp)
            MDU_MULT, MDU_MULTU: begin
              a_d     = A;
              b_d     = B;
              op_d    = mduOp;
              cnt_d   = MULT_LOAD;
              state_d = BUSY;
            end
            MDU_DIV, MDU_DIVU: begin
              a_d     = A;
              b_d     = B;
              op_d    = mduOp;
              cnt_d   = DIV_LOAD;
              state_d = BUSY;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          // A zero divisor leaves HI/LO untouched; signed overflow is pinned explicitly.
          case (op_q)
            MDU_MULT:  {hi_d, lo_d} = prod_s;
            MDU_MULTU: {hi_d, lo_d} = prod_u;
            MDU_DIV: begin
              if (div_ovf) begin
                lo_d = 32'h8000_0000;
                hi_d = 32'b0;
              end else if (!div_zero) begin
                lo_d = quot_s;
                hi_d = rem_s;
              end
            end
            MDU_DIVU: begin
              if (!div_zero) begin
                lo_d = quot_u;
                hi_d = rem_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'b0;
      lo_q    <= 32'b0;
      a_q     <= 32'b0;
      b_q     <= 32'b0;
      op_q    <= MDU_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign mduOut = (mduOp == MDU_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult_div_unit;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mduOp = MDU_NONE;
  logic [31:0] A = 32'b0;
  logic [31:0] B = 32'b0;
  logic        busy;
  logic [31:0] hi, lo, mduOut;

  int checks = 0;
  int errors = 0;
  int n;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mduOp(mduOp),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo), .mduOut(mduOut)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; the op is sampled on the next rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    mduOp = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    mduOp = MDU_NONE;
  endtask

  // Counts remaining busy cycles, bounded so a stuck unit cannot hang the run.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    checks++;
    if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi got %h want 00000000", hi); end
    checks++;
    if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo got %h want 00000000", lo); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mt();
    issue(MDU_MTHI, 32'h1234_5678, 32'h0);
    checks++;
    if (hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mthi got %h want 12345678", hi); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy got %0b want 0", busy); end
    issue(MDU_MTLO, 32'h9ABC_DEF0, 32'h0);
    checks++;
    if (lo !== 32'h9ABC_DEF0) begin errors++; $display("[TB] FAIL mtlo got %h want 9abcdef0", lo); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_busy got %0b want 0", busy); end
    mduOp = MDU_MFHI;
    #1;
    checks++;
    if (mduOut !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mfhi_read got %h want 12345678", mduOut); end
    mduOp = MDU_NONE;
  endtask

  task automatic test_mult();
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    checks++;
    if (n !== 5) begin errors++; $display("[TB] FAIL mult_latency got %0d want 5", n); end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      errors++; $display("[TB] FAIL mult_result got %h_%h want ffffffff_fffffffa", hi, lo);
    end
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    checks++;
    if (n !== 5) begin errors++; $display("[TB] FAIL multu_latency got %0d want 5", n); end
    checks++;
    if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin
      errors++; $display("[TB] FAIL multu_result got %h_%h want 00000002_fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++;
    if (n !== 10) begin errors++; $display("[TB] FAIL div_latency got %0d want 10", n); end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("[TB] FAIL div_result got %h_%h want ffffffff_fffffffd", hi, lo);
    end
    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    checks++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003) begin
      errors++; $display("[TB] FAIL divu_result got %h_%h want 00000001_00000003", hi, lo);
    end
  endtask

  task automatic test_div_edge();
    issue(MDU_MTHI, 32'hAAAA_0000, 32'h0);
    issue(MDU_MTLO, 32'h0000_BBBB, 32'h0);
    issue(MDU_DIV, 32'h0000_1234, 32'h0);
    wait_idle(n);
    checks++;
    if (n !== 10) begin errors++; $display("[TB] FAIL divzero_latency got %0d want 10", n); end
    checks++;
    if ({hi, lo} !== 64'hAAAA_0000_0000_BBBB) begin
      errors++; $display("[TB] FAIL divzero_hold got %h_%h want aaaa0000_0000bbbb", hi, lo);
    end
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("[TB] FAIL div_overflow got %h_%h want 00000000_80000000", hi, lo);
    end
  endtask

  task automatic test_busy_ignore();
    issue(MDU_MTLO, 32'h0BAD_F00D, 32'h0);
    issue(MDU_MULT, 32'd5, 32'd7);
    start = 1'b1;
    mduOp = MDU_MTLO;
    A     = 32'hDEAD_BEEF;
    B     = 32'h0000_0099;
    @(negedge clk);
    start = 1'b0;
    mduOp = MDU_MFLO;
    A     = 32'h1111_1111;
    B     = 32'h2222_2222;
    #1;
    checks++;
    if (mduOut !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL mflo_busy got %h want 0badf00d", mduOut); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid got %0b want 1", busy); end
    wait_idle(n);
    checks++;
    if (n + 1 !== 5) begin errors++; $display("[TB] FAIL ignore_latency got %0d want 5", n + 1); end
    checks++;
    if ({hi, lo} !== 64'd35) begin errors++; $display("[TB] FAIL ignore_result got %h_%h want 00000000_00000023", hi, lo); end
    mduOp = MDU_NONE;
  endtask

  task automatic test_reset_abort();
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %0b want 0", busy); end
    checks++;
    if ({hi, lo} !== 64'h0) begin errors++; $display("[TB] FAIL abort_hilo got %h_%h want 0_0", hi, lo); end
    reset = 1'b1;
    @(negedge clk);
    issue(MDU_MULT, 32'd6, 32'd7);
    wait_idle(n);
    checks++;
    if (n !== 5) begin errors++; $display("[TB] FAIL post_reset_latency got %0d want 5", n); end
    checks++;
    if ({hi, lo} !== 64'd42) begin errors++; $display("[TB] FAIL post_reset_mult got %h_%h want 0_2a", hi, lo); end
  endtask

  task automatic test_back_to_back();
    issue(MDU_MULT, 32'd3, 32'd4);
    wait_idle(n);
    issue(MDU_MTLO, 32'h0000_0055, 32'h0);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_0055) begin
      errors++; $display("[TB] FAIL b2b_mtlo got %h_%h want 00000000_00000055", hi, lo);
    end
    issue(4'hF, 32'hFFFF_0000, 32'd1);
    issue(MDU_NONE, 32'hFFFF_0000, 32'd1);
    issue(MDU_MFHI, 32'hFFFF_0000, 32'd1);
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== 64'h55) begin
      errors++; $display("[TB] FAIL undef_op got busy=%0b %h_%h want 0 00000000_00000055", busy, hi, lo);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mt();
    test_mult();
    test_div();
    test_div_edge();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
